pe_mac_pipe: RTL and testbench

- Next-generation systolic processing element for the matrix-multiply array.
- Forwards A/B operands to neighbour PEs with a valid tag and accumulates a dot product of K_DEPTH terms through a registered multiply stage.
- Adds signed/unsigned mode, correct sticky overflow detection, optional saturation, in-place clear and a done indication per dot product.

---
 rtl/pe_mac_pipe_pkg.sv | 14 +
 rtl/pe_sat_add.sv | 36 +++
 rtl/pe_mac_pipe.sv | 139 +++++++++++++
 tb/tb_pe_mac_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_pipe_pkg.sv
// Shared definitions for the systolic MAC processing element and its array controller.
// State encodings are plain constants so legacy controllers can compare against them directly.
package pe_mac_pipe_pkg;

  localparam logic [1:0] PE_IDLE  = 2'd0;
  localparam logic [1:0] PE_ACCUM = 2'd1;
  localparam logic [1:0] PE_DONE  = 2'd2;

  // Width of a counter that walks 0..depth-1; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational accumulator adder with signed/unsigned overflow detection
// and optional clamping to the range of the selected mode.
module pe_sat_add #(
  parameter int ACC_WIDTH = 64,
  parameter int SATURATE  = 0
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  input  logic                 signed_mode,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int MSB = ACC_WIDTH - 1;

  logic [ACC_WIDTH:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};

  // Signed overflow: equal-sign addends whose sum changes sign; unsigned: carry out.
  always_comb begin
    overflow = signed_mode ? ((a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]))
                           : raw[ACC_WIDTH];
    sum = raw[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && overflow) begin
      if (!signed_mode) begin
        sum = '1;
      end else if (a[MSB]) begin
        sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pe_mac_pipe.sv
// Systolic PE: forwards A/B/valid to neighbours and accumulates a K_DEPTH-term
// dot product through a registered multiply stage with sticky overflow.
module pe_mac_pipe
  import pe_mac_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int K_DEPTH    = 4,
  parameter int SATURATE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  signed_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  valid_o,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  overflow_o,
  output logic                  done_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = cnt_width(K_DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K_DEPTH - 1);

  logic [PROD_W-1:0]    a_x, b_x, prod_d, prod_q;
  logic                 prod_v_q, mode_q;
  logic [ACC_WIDTH-1:0] acc_q, prod_ext, sum;
  logic                 add_ovf;
  logic [1:0]           state_q;
  logic [CNT_W-1:0]     count_q;

  // Extending both operands by mode makes the truncated product correct for either signedness.
  assign a_x    = {{DATA_WIDTH{signed_i & a_i[DATA_WIDTH-1]}}, a_i};
  assign b_x    = {{DATA_WIDTH{signed_i & b_i[DATA_WIDTH-1]}}, b_i};
  assign prod_d = a_x * b_x;

  always_comb begin
    prod_ext = '0;
    prod_ext[PROD_W-1:0] = prod_q;
    for (int i = PROD_W; i < ACC_WIDTH; i++) begin
      prod_ext[i] = mode_q & prod_q[PROD_W-1];
    end
  end

  pe_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_add (
    .a           (acc_q),
    .b           (prod_ext),
    .signed_mode (mode_q),
    .sum         (sum),
    .overflow    (add_ovf)
  );

  assign res_o = acc_q;

  // start_i low flushes everything; clear_i restarts the dot product, possibly seeding it
  // with the product arriving in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_o        <= '0;
      b_o        <= '0;
      valid_o    <= 1'b0;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      mode_q     <= 1'b0;
      acc_q      <= '0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
      count_q    <= '0;
      state_q    <= PE_IDLE;
    end else if (!start_i) begin
      a_o        <= '0;
      b_o        <= '0;
      valid_o    <= 1'b0;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      acc_q      <= '0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
      count_q    <= '0;
      state_q    <= PE_IDLE;
    end else begin
      a_o      <= a_i;
      b_o      <= b_i;
      valid_o  <= valid_i;
      prod_q   <= prod_d;
      prod_v_q <= valid_i;
      mode_q   <= signed_i;
      if (clear_i) begin
        overflow_o <= 1'b0;
        if (prod_v_q) begin
          acc_q <= prod_ext;
          if (K_DEPTH == 1) begin
            count_q <= '0;
            done_o  <= 1'b1;
            state_q <= PE_DONE;
          end else begin
            count_q <= CNT_W'(1);
            done_o  <= 1'b0;
            state_q <= PE_ACCUM;
          end
        end else begin
          acc_q   <= '0;
          count_q <= '0;
          done_o  <= 1'b0;
          state_q <= PE_ACCUM;
        end
      end else begin
        case (state_q)
          PE_IDLE: state_q <= PE_ACCUM;
          PE_ACCUM: begin
            if (prod_v_q) begin
              acc_q      <= sum;
              overflow_o <= overflow_o | add_ovf;
              if (count_q == LAST) begin
                count_q <= '0;
                done_o  <= 1'b1;
                state_q <= PE_DONE;
              end else begin
                count_q <= count_q + CNT_W'(1);
              end
            end
          end
          PE_DONE: state_q <= PE_DONE;
          default: state_q <= PE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: wrapping and saturating instances share stimulus and are
// compared against an integer-arithmetic reference model.
module tb_pe_mac_pipe;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int K  = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni, start_i, clear_i, signed_i, valid_i;
  logic [DW-1:0] a_i, b_i;
  logic [DW-1:0] w_a_o, w_b_o, s_a_o, s_b_o;
  logic          w_valid_o, s_valid_o, w_ovf, s_ovf, w_done, s_done;
  logic [AW-1:0] w_res, s_res;

  pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_DEPTH(K), .SATURATE(0)) dut_wrap (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .signed_i(signed_i), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .a_o(w_a_o), .b_o(w_b_o), .valid_o(w_valid_o), .res_o(w_res),
    .overflow_o(w_ovf), .done_o(w_done)
  );

  pe_mac_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_DEPTH(K), .SATURATE(1)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
    .signed_i(signed_i), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .a_o(s_a_o), .b_o(s_b_o), .valid_o(s_valid_o), .res_o(s_res),
    .overflow_o(s_ovf), .done_o(s_done)
  );

  // phase: 0 idle, 1 accumulating, 2 done; acc kept as raw 0..65535, n counts accepted terms.
  typedef struct {
    int         phase;
    int         acc;
    int         n;
    bit         ovf;
    bit         done;
    bit         pv;
    bit         pm;
    int         pp;
    logic [7:0] fa;
    logic [7:0] fb;
    bit         fv;
  } mdl_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        v;
    logic [15:0] res0;
    logic        ovf0;
    logic        done0;
    logic [15:0] res1;
    logic        ovf1;
    logic        done1;
  } exp_t;

  exp_t       exp_q[$];
  mdl_t       m_wrap, m_sat;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] edge_vals[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  function automatic mdl_t mdl_step(input mdl_t m, input bit sat, input bit start, input bit clr,
                                    input bit sgn, input bit vld, input logic [7:0] a,
                                    input logic [7:0] b);
    mdl_t r;
    int   sa, s;
    bit   of;
    byte  ab, bb;
    r = m;
    if (!start) begin
      r = '{default: 0};
      return r;
    end
    r.fa = a;
    r.fb = b;
    r.fv = vld;
    if (clr) begin
      r.ovf = 0; r.done = 0; r.phase = 1; r.n = 0; r.acc = 0;
      if (m.pv) begin
        r.acc = m.pp & 32'hFFFF;
        r.n   = 1;
        if (K == 1) begin r.phase = 2; r.done = 1; end
      end
    end else if (m.phase == 0) begin
      r.phase = 1;
    end else if (m.phase == 1 && m.pv) begin
      if (m.pm) begin
        sa = (m.acc >= 32768) ? m.acc - 65536 : m.acc;
        s  = sa + m.pp;
        of = (s > 32767) || (s < -32768);
        if (of && sat) s = (s > 0) ? 32767 : -32768;
      end else begin
        s  = m.acc + m.pp;
        of = s > 65535;
        if (of && sat) s = 65535;
      end
      r.acc = s & 32'hFFFF;
      r.ovf = m.ovf | of;
      r.n   = m.n + 1;
      if (r.n == K) begin r.phase = 2; r.done = 1; end
    end
    ab = a;
    bb = b;
    r.pv = vld;
    r.pm = sgn;
    r.pp = sgn ? int'(ab) * int'(bb) : int'(a) * int'(b);
    return r;
  endfunction

  task automatic check_output(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: actual=0x%0h required=0x%0h", name, $time, act, req);
    end
  endtask

  // Drive inputs for the coming edge and queue what both instances must show after it.
  task automatic drive_now(input bit start, input bit clr, input bit sgn, input bit vld,
                           input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start_i = start; clear_i = clr; signed_i = sgn; valid_i = vld; a_i = a; b_i = b;
    m_wrap = mdl_step(m_wrap, 0, start, clr, sgn, vld, a, b);
    m_sat  = mdl_step(m_sat, 1, start, clr, sgn, vld, a, b);
    e.a = m_wrap.fa; e.b = m_wrap.fb; e.v = m_wrap.fv;
    e.res0 = 16'(m_wrap.acc); e.ovf0 = m_wrap.ovf; e.done0 = m_wrap.done;
    e.res1 = 16'(m_sat.acc);  e.ovf1 = m_sat.ovf;  e.done1 = m_sat.done;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit start, input bit clr, input bit sgn, input bit vld,
                                input logic [7:0] a, input logic [7:0] b);
    @(negedge clk_i);
    drive_now(start, clr, sgn, vld, a, b);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_res_wrap"}, w_res, 0);
    check_output({tag, "_res_sat"}, s_res, 0);
    check_output({tag, "_ovf"}, {w_ovf, s_ovf}, 0);
    check_output({tag, "_done"}, {w_done, s_done}, 0);
    check_output({tag, "_fwd"}, {w_a_o, w_b_o, w_valid_o, s_a_o, s_b_o, s_valid_o}, 0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    start_i = 1'b1; clear_i = 1'b0; signed_i = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    check_all_zero(tag);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m_wrap = '{default: 0};
    m_sat  = '{default: 0};
    drive_now(1, 0, 0, 0, 8'h00, 8'h00);
  endtask

  // Monitor: every edge outside reset presents a full output set to compare.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (rst_ni && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("a_o_wrap", w_a_o, e.a);
      check_output("b_o_wrap", w_b_o, e.b);
      check_output("valid_o_wrap", w_valid_o, e.v);
      check_output("a_o_sat", s_a_o, e.a);
      check_output("b_o_sat", s_b_o, e.b);
      check_output("valid_o_sat", s_valid_o, e.v);
      check_output("res_wrap", w_res, e.res0);
      check_output("ovf_wrap", w_ovf, e.ovf0);
      check_output("done_wrap", w_done, e.done0);
      check_output("res_sat", s_res, e.res1);
      check_output("ovf_sat", s_ovf, e.ovf1);
      check_output("done_sat", s_done, e.done1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         r_start, r_clr, r_sgn, r_vld;
    logic [7:0] ra, rb;
    m_wrap = '{default: 0};
    m_sat  = '{default: 0};
    rst_ni = 1'b0;
    start_i = 1'b0; clear_i = 1'b0; signed_i = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    check_all_zero("por");
    async_reset("por2");

    // Reset mid-accumulation with res_o = 37.
    apply_stimulus(1, 1, 0, 0, 8'd0, 8'd0);
    apply_stimulus(1, 0, 0, 1, 8'd37, 8'd1);
    apply_stimulus(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check_output("res_37", w_res, 37);
    async_reset("mid_reset");
    settle();
    check_output("post_reset_res", w_res, 0);

    // Signed dot product of 3 * -2, four terms, then an ignored fifth term.
    apply_stimulus(1, 1, 1, 0, 8'd0, 8'd0);
    repeat (4) apply_stimulus(1, 0, 1, 1, 8'd3, 8'hFE);
    apply_stimulus(1, 0, 1, 1, 8'd1, 8'd1);
    apply_stimulus(1, 0, 1, 0, 8'd0, 8'd0);
    settle();
    check_output("dot_res", w_res, 16'hFFE8);
    check_output("dot_done", w_done, 1);

    // -128 * -128 repeated: wrap vs clamp, sticky overflow, clear.
    apply_stimulus(1, 1, 1, 0, 8'd0, 8'd0);
    repeat (4) apply_stimulus(1, 0, 1, 1, 8'h80, 8'h80);
    apply_stimulus(1, 0, 1, 0, 8'd0, 8'd0);
    settle();
    check_output("wrap_ovf", w_ovf, 1);
    check_output("sat_res_max", s_res, 16'h7FFF);
    apply_stimulus(1, 1, 1, 0, 8'd0, 8'd0);
    settle();
    check_output("clear_res", {w_res, s_res}, 0);
    check_output("clear_ovf", {w_ovf, s_ovf}, 0);

    // -128 * 127 three times clamps to the signed minimum.
    repeat (3) apply_stimulus(1, 0, 1, 1, 8'h80, 8'h7F);
    apply_stimulus(1, 0, 1, 0, 8'd0, 8'd0);
    settle();
    check_output("sat_res_min", s_res, 16'h8000);

    // Unsigned 255 * 255 twice.
    apply_stimulus(1, 1, 0, 0, 8'd0, 8'd0);
    repeat (2) apply_stimulus(1, 0, 0, 1, 8'hFF, 8'hFF);
    apply_stimulus(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check_output("uns_wrap", w_res, 64514);
    check_output("uns_sat", s_res, 16'hFFFF);
    check_output("uns_ovf", {w_ovf, s_ovf}, 2'b11);

    // Clear coinciding with a queued 5*6 product seeds a new dot product.
    apply_stimulus(1, 0, 0, 1, 8'd2, 8'd2);
    apply_stimulus(1, 1, 0, 0, 8'd0, 8'd0);
    apply_stimulus(1, 0, 0, 1, 8'd2, 8'd2);
    apply_stimulus(1, 0, 0, 1, 8'd5, 8'd6);
    apply_stimulus(1, 1, 0, 0, 8'd0, 8'd0);
    apply_stimulus(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check_output("seed_res", w_res, 30);
    check_output("seed_done", w_done, 0);
    repeat (3) apply_stimulus(1, 0, 0, 1, 8'd1, 8'd1);
    repeat (2) apply_stimulus(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check_output("seed_total", w_res, 33);
    check_output("seed_total_done", w_done, 1);

    // start_i low wins over clear_i and valid_i.
    apply_stimulus(0, 1, 1, 1, 8'd7, 8'd7);
    settle();
    check_all_zero("flush");

    // Randomized traffic with biased control and frequent extreme operands.
    for (int i = 0; i < 1500; i++) begin
      r_start = $urandom_range(0, 99) < 97;
      r_clr   = $urandom_range(0, 99) < 6;
      r_sgn   = 1'($urandom);
      r_vld   = $urandom_range(0, 99) < 75;
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 8'($urandom);
      apply_stimulus(r_start, r_clr, r_sgn, r_vld, ra, rb);
    end
    apply_stimulus(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    settle();
    check_output("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
